// File: rtl/pix_mean_feeder.sv
// Pixel sum/count feeder for the Div_0 mean divider; result goes to the sort stage.
// Optional build macro PIX_MEAN_SAT_EN: saturating sum plus sticky sat_flag.
module pix_mean_feeder #(
  parameter int PIX_W   = 8,
  parameter int MAX_PIX = 16384,
  parameter int DIV_LAT = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic [21:0]      dv_out,
  output logic [14:0]      dvn_out,
  output logic             div_load_n,
  input  logic [21:0]      div_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [21:0]      res_q,
  output logic [4:0]       res_idx,
`ifdef PIX_MEAN_SAT_EN
  output logic             sat_flag,
`endif
  output logic             busy
);

  localparam int WC_W = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {
    ACC,
    LOAD,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [21:0]     sum;
  logic [14:0]     count;
  logic [WC_W-1:0] wcnt;
  logic            accept;
  logic            close;
  logic [21:0]     sum_nxt;

  assign accept = pix_valid & pix_ready;
  assign close  = pix_last | (count == 15'(MAX_PIX - 1));

`ifdef PIX_MEAN_SAT_EN
  logic [22:0] sum_ext;
  logic        sat_hit;

  assign sum_ext = {1'b0, sum} + 23'(pix_data);
  assign sat_hit = sum_ext[22];
  assign sum_nxt = sat_hit ? 22'h3FFFFF : sum_ext[21:0];
`else
  assign sum_nxt = sum + 22'(pix_data);
`endif

  // Operands come straight from the accumulators so the divider sees
  // the same bits from the load pulse until the result is taken.
  assign dv_out  = sum;
  assign dvn_out = count;
  assign busy    = (state != ACC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACC;
      sum        <= '0;
      count      <= '0;
      wcnt       <= '0;
      res_q      <= '0;
      res_idx    <= '0;
      res_valid  <= 1'b0;
      pix_ready  <= 1'b0;
      div_load_n <= 1'b1;
`ifdef PIX_MEAN_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ACC: begin
          pix_ready <= 1'b1;
          if (accept) begin
            sum   <= sum_nxt;
            count <= count + 15'd1;
`ifdef PIX_MEAN_SAT_EN
            if (sat_hit) sat_flag <= 1'b1;
`endif
            if (close) begin
              state      <= LOAD;
              pix_ready  <= 1'b0;
              div_load_n <= 1'b0;
            end
          end
        end
        LOAD: begin
          div_load_n <= 1'b1;
          wcnt       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (wcnt == WC_W'(DIV_LAT)) begin
            res_q     <= div_q;
            res_valid <= 1'b1;
            wcnt      <= '0;
            state     <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            sum       <= '0;
            count     <= '0;
            res_idx   <= res_idx + 5'd1;
            res_valid <= 1'b0;
            pix_ready <= 1'b1;
            state     <= ACC;
`ifdef PIX_MEAN_SAT_EN
            sat_flag  <= 1'b0;
`endif
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_mean_feeder.sv
// Directed bench for pix_mean_feeder with a behavioural Div_0 model.
// Instance a: default MAX_PIX; instance b: MAX_PIX=4.
module tb_pix_mean_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pv, pl, rr, sel;
  logic [7:0] pd;

  logic        a_pr, a_ld, a_rv, a_busy;
  logic [21:0] a_dv, a_dq, a_rq;
  logic [14:0] a_dvn;
  logic [4:0]  a_ri;
  logic        b_pr, b_ld, b_rv, b_busy;
  logic [21:0] b_dv, b_dq, b_rq;
  logic [14:0] b_dvn;
  logic [4:0]  b_ri;
`ifdef PIX_MEAN_SAT_EN
  logic a_sat, b_sat;
`endif

  function automatic logic [21:0] divm(input logic [21:0] s,
                                       input logic [14:0] c);
    logic [35:0] n;
    if (c == 15'd0) return 22'd0;
    n = {s, 14'b0};
    return 22'(n / 36'(c));
  endfunction

  assign a_dq = divm(a_dv, a_dvn);
  assign b_dq = divm(b_dv, b_dvn);

  pix_mean_feeder u_a (
    .clk(clk), .rst(rst),
    .pix_valid(pv & ~sel), .pix_ready(a_pr),
    .pix_data(pd), .pix_last(pl),
    .dv_out(a_dv), .dvn_out(a_dvn), .div_load_n(a_ld),
    .div_q(a_dq), .res_valid(a_rv), .res_ready(rr & ~sel),
    .res_q(a_rq), .res_idx(a_ri),
`ifdef PIX_MEAN_SAT_EN
    .sat_flag(a_sat),
`endif
    .busy(a_busy)
  );

  pix_mean_feeder #(.MAX_PIX(4)) u_b (
    .clk(clk), .rst(rst),
    .pix_valid(pv & sel), .pix_ready(b_pr),
    .pix_data(pd), .pix_last(pl),
    .dv_out(b_dv), .dvn_out(b_dvn), .div_load_n(b_ld),
    .div_q(b_dq), .res_valid(b_rv), .res_ready(rr & sel),
    .res_q(b_rq), .res_idx(b_ri),
`ifdef PIX_MEAN_SAT_EN
    .sat_flag(b_sat),
`endif
    .busy(b_busy)
  );

  logic        t_pr, t_ld, t_rv, t_busy;
  logic [21:0] t_dv, t_rq;
  logic [14:0] t_dvn;
  logic [4:0]  t_ri;
  assign t_pr   = sel ? b_pr   : a_pr;
  assign t_ld   = sel ? b_ld   : a_ld;
  assign t_rv   = sel ? b_rv   : a_rv;
  assign t_busy = sel ? b_busy : a_busy;
  assign t_dv   = sel ? b_dv   : a_dv;
  assign t_rq   = sel ? b_rq   : a_rq;
  assign t_dvn  = sel ? b_dvn  : a_dvn;
  assign t_ri   = sel ? b_ri   : a_ri;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int k;
    @(negedge clk);
    pv = 1'b1;
    pd = d;
    pl = last;
    k  = 0;
    while (!t_pr && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("beat_accept", 32'(t_pr), 1);
    @(posedge clk);
  endtask

  task automatic check_res(input logic [21:0] es, input logic [14:0] ec,
                           input logic [21:0] eq, input logic [4:0] ei,
                           input bit hold);
    int cyc, lows;
    bit stab;
    logic [21:0] q0;
    logic [4:0]  i0;
    @(negedge clk);
    pv = 1'b0;
    pl = 1'b0;
    chk("dv_at_load", 32'(t_dv), 32'(es));
    chk("dvn_at_load", 32'(t_dvn), 32'(ec));
    chk("load_n_low", 32'(t_ld), 0);
    cyc  = 0;
    lows = 1;
    stab = 1'b1;
    while (!t_rv && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!t_ld) lows++;
      if (t_dv !== es || t_dvn !== ec) stab = 1'b0;
    end
    chk("latency", 32'(cyc), 40);
    chk("load_pulses", 32'(lows), 1);
    chk("operand_stable", 32'(stab), 1);
    chk("res_q", 32'(t_rq), 32'(eq));
    chk("res_idx", 32'(t_ri), 32'(ei));
    if (hold) begin
      q0   = t_rq;
      i0   = t_ri;
      stab = 1'b1;
      pv   = 1'b1;
      pd   = 8'd99;
      pl   = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (!t_rv || t_rq !== q0 || t_ri !== i0 || t_pr
            || t_dvn !== ec) stab = 1'b0;
      end
      pv = 1'b0;
      pl = 1'b0;
      chk("hold_stable", 32'(stab), 1);
    end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    chk("ready_after_hs", 32'(t_pr), 1);
    chk("valid_cleared", 32'(t_rv), 0);
    chk("dvn_cleared", 32'(t_dvn), 0);
  endtask

  task automatic run_pic(input int n, input logic [3:0][7:0] p,
                         input logic [21:0] es, input logic [14:0] ec,
                         input logic [21:0] eq, input logic [4:0] ei,
                         input bit hold);
    for (int i = 0; i < n; i++) send_beat(p[i], i == n - 1);
    check_res(es, ec, eq, ei, hold);
  endtask

  typedef struct {
    int               n;
    logic [3:0][7:0]  p;
    logic [21:0]      s;
    logic [14:0]      c;
    logic [21:0]      q;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4, {8'd40, 8'd30, 8'd20, 8'd10}, 22'd100, 15'd4, 22'd409600};
    tbl[1] = '{1, {8'd0, 8'd0, 8'd0, 8'd5}, 22'd5, 15'd1, 22'd81920};
    tbl[2] = '{3, {8'd0, 8'd3, 8'd2, 8'd1}, 22'd6, 15'd3, 22'd32768};
    tbl[3] = '{2, {8'd0, 8'd0, 8'd0, 8'd0}, 22'd0, 15'd2, 22'd0};
    tbl[4] = '{4, {8'd1, 8'd255, 8'd0, 8'd255}, 22'd511, 15'd4,
               22'd2093056};

    rst = 1'b0;
    pv  = 1'b0;
    pl  = 1'b0;
    pd  = 8'd0;
    rr  = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", 32'(t_pr), 0);
    chk("rst_load_n", 32'(t_ld), 1);
    chk("rst_res_valid", 32'(t_rv), 0);
    chk("rst_res_q", 32'(t_rq), 0);
    chk("rst_res_idx", 32'(t_ri), 0);
    chk("rst_dvn", 32'(t_dvn), 0);
    chk("rst_busy", 32'(t_busy), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(t_pr), 1);

    for (int i = 0; i < 5; i++)
      run_pic(tbl[i].n, tbl[i].p, tbl[i].s, tbl[i].c, tbl[i].q,
              5'(i), i == 0);

    // reset while the divider load pulse is low
    send_beat(8'd50, 1'b1);
    @(negedge clk);
    pv = 1'b0;
    pl = 1'b0;
    chk("pre_load_n", 32'(t_ld), 0);
    #2 rst = 1'b0;
    #1;
    chk("async_load_n", 32'(t_ld), 1);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-WAIT
    send_beat(8'd60, 1'b1);
    @(negedge clk);
    pv = 1'b0;
    pl = 1'b0;
    repeat (10) @(negedge clk);
    chk("wait_busy", 32'(t_busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_load_n", 32'(t_ld), 1);
    chk("mid_rst_valid", 32'(t_rv), 0);
    chk("mid_rst_dv", 32'(t_dv), 0);
    chk("mid_rst_busy", 32'(t_busy), 0);
    chk("mid_rst_ready", 32'(t_pr), 0);
    @(negedge clk);
    rst = 1'b1;
    run_pic(2, {8'd0, 8'd0, 8'd9, 8'd7}, 22'd16, 15'd2, 22'd131072,
            5'd0, 1'b0);
    run_pic(2, {8'd0, 8'd0, 8'd9, 8'd7}, 22'd16, 15'd2, 22'd131072,
            5'd1, 1'b0);

    // single-pixel pictures walking res_idx through the wrap
    for (int k = 2; k < 33; k++)
      run_pic(1, {8'd0, 8'd0, 8'd0, 8'd255}, 22'd255, 15'd1,
              22'd4177920, 5'(k), 1'b0);

    // MAX_PIX=4 instance: six beats of 1 without pix_last
    sel = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'd1, 1'b0);
    check_res(22'd4, 15'd4, 22'd16384, 5'd0, 1'b0);
    send_beat(8'd1, 1'b0);
    send_beat(8'd1, 1'b0);
    @(negedge clk);
    pv = 1'b0;
    chk("max_carry_count", 32'(t_dvn), 2);
    chk("max_carry_busy", 32'(t_busy), 0);
    send_beat(8'd1, 1'b0);
    send_beat(8'd1, 1'b0);
    check_res(22'd4, 15'd4, 22'd16384, 5'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pix_mean_feeder.md
Name: pix_mean_feeder

Overview:
- Upstream stage of the Div_0 divider in the image sorting engine.
- Accumulates 8-bit pixel intensities and the pixel count for one picture.
- Drives the divider with dividend = sum and divisor = count, holds those operands stable for the divider's full iteration time, then captures the quotient.
- Presents the mean-brightness result (14 fractional bits) plus a 5-bit image index to the sort stage over a valid/ready handshake.

Parameters:
- PIX_W, 8, pixel intensity width.
- MAX_PIX, 16384, maximum pixels per picture; the beat that reaches this count is treated as last.
- DIV_LAT, 38, cycles the operands are held after the divider load pulse before div_q is sampled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel beat valid.
- pix_ready  out  1  feeder accepts a pixel this cycle.
- pix_data  in  PIX_W  pixel intensity.
- pix_last  in  1  final pixel of the picture.
- dv_out  out  22  dividend to the divider (pixel sum).
- dvn_out  out  15  divisor to the divider (pixel count).
- div_load_n  out  1  active-low divider load, drives the divider's reset input.
- div_q  in  22  divider quotient.
- res_valid  out  1  result available.
- res_ready  in  1  sort stage accepts the result.
- res_q  out  22  captured mean, 14 fractional bits.
- res_idx  out  5  image index of res_q.
- busy  out  1  high in LOAD, WAIT and DONE.

Behaviour:
- Reset (rst=0, asynchronous) clears these outputs and registers to 0:
  - sum, count, res_q, res_idx, wait counter.
  - res_valid=0, pix_ready=0, div_load_n=1.
  - state=ACC.
- pix_ready becomes 1 on the first clock after reset release.
- States: ACC, LOAD, WAIT, DONE.
- ACC:
  - pix_ready=1.
  - On each accepted beat (pix_valid & pix_ready): sum += pix_data (zero-extended to 22 bits) and count += 1.
  - The accepted beat with pix_last=1, or the beat that makes count == MAX_PIX, moves the state to LOAD on the next edge. The final pixel's value is included in the sum.
- LOAD:
  - Exactly one cycle.
  - div_load_n=0; pix_ready=0.
  - dv_out and dvn_out already hold the final sum and count.
- WAIT:
  - div_load_n=1.
  - The counter runs 1..DIV_LAT.
  - dv_out and dvn_out must stay bit-stable for the whole state, because the divider recomputes its shift amount combinationally from them.
  - When the counter reaches DIV_LAT: res_q <= div_q, res_valid <= 1, state -> DONE.
- DONE:
  - res_valid=1; res_q and res_idx stay stable until the handshake.
  - On res_valid & res_ready:
    - sum <= 0, count <= 0.
    - res_idx <= res_idx+1, wrapping 31 -> 0.
    - res_valid <= 0, state -> ACC.
  - pix_ready returns to 1 in the cycle after the handshake.
- Operand outputs: dv_out = sum and dvn_out = count at all times. Both read 0 in ACC after clear. The divisor is never 0 when div_load_n=0, because at least one beat is always counted.
- Zero-extension: count never exceeds MAX_PIX ≤ 32767 and is zero-extended to 15 bits.
- Latency: last accepted pixel edge to res_valid=1 is DIV_LAT+2 cycles.
- pix_last with pix_valid=0 is ignored.
- Pixels offered in LOAD, WAIT or DONE are back-pressured, not dropped.
- Reset during LOAD or WAIT: the partial result is discarded, div_load_n returns to 1 immediately (asynchronous), and res_idx returns to 0.

Optional Feature:
- Macro: PIX_MEAN_SAT_EN.
- Defined:
  - The sum saturates at 22'h3FFFFF instead of wrapping.
  - A sticky output sat_flag (1 bit) is set when saturation occurs and cleared on the DONE handshake and on reset.
- Undefined:
  - The sum wraps modulo 2^22.
  - The sat_flag port does not exist.

Test Plan:
- Pixels 10, 20, 30, 40 with last on 40 → dv_out=100, dvn_out=4, one div_load_n low pulse; with a Div_0 model, res_q=409600 (0x64000) and res_idx=0, res_valid exactly DIV_LAT+2 cycles after the last beat.
- Hold res_ready=0 for 20 cycles in DONE → res_valid, res_q and res_idx stable; pix_ready=0; pix_valid beats are not accepted. Then release → next picture gets res_idx=1.
- 33 single-pixel pictures of value 255 → each res_q=255<<14=4177920; res_idx sequence 0..31,0.
- MAX_PIX=4 with 6 beats of value 1 and no pix_last → the picture closes after 4 beats with dvn_out=4, res_q=16384; the remaining 2 beats start the next picture.
- rst=0 asserted mid-WAIT → outputs return to reset values within the cycle; after release, a new picture of 7, 9 gives res_q=8<<14=131072 with res_idx=0.
- With PIX_MEAN_SAT_EN defined and MAX_PIX=32767, 16449 beats of 255 → sum clamps at 4194303 and sat_flag=1; without the macro, dv_out=(16449*255) mod 2^22.
